// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } key_state_t;

    localparam int DEF_NUM_KEYS          = 2;
    localparam int DEF_DEBOUNCE_CYCLES   = 270000;    // 10 ms at 27 MHz
    localparam int DEF_LONG_PRESS_CYCLES = 27000000;  // 1 s at 27 MHz

    // Counter width for a count of 0..limit-1; never below one bit.
    function automatic int cnt_w(input int limit);
        return (limit < 3) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, debounce FSM, optional long-press
// hold counter (built only when KEY_LONG_PRESS_EN is defined).
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int              DB_W    = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      r_sync;
    logic            w_low;
    key_state_t      r_state;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;

`ifdef KEY_LONG_PRESS_EN
    localparam int                HOLD_W    = cnt_w(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_long_done;
    logic              r_long;

    assign o_long = r_long;
`else
    assign o_long = 1'b0;
`endif

    // Synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], i_key_n};
    end

    assign w_low = ~r_sync[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            r_long    <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_low) begin
                        r_state  <= ST_PRESS_DB;
                        r_db_cnt <= '0;
                    end
                end
                ST_PRESS_DB: begin
                    if (!w_low) begin
                        r_state  <= ST_IDLE;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state  <= ST_HELD;
                        r_db_cnt <= '0;
                        r_level  <= 1'b1;
                        r_press  <= 1'b1;
`ifdef KEY_LONG_PRESS_EN
                        r_hold_cnt  <= '0;
                        r_long_done <= 1'b0;
`endif
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!w_low) begin
                        r_state  <= ST_REL_DB;
                        r_db_cnt <= '0;
                    end
`ifdef KEY_LONG_PRESS_EN
                    // Saturates at the limit; the done flag keeps a bounce from re-firing.
                    else if (r_hold_cnt == HOLD_LAST) begin
                        if (!r_long_done) begin
                            r_long      <= 1'b1;
                            r_long_done <= 1'b1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
`endif
                end
                ST_REL_DB: begin
                    if (w_low) begin
                        r_state  <= ST_HELD;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state   <= ST_IDLE;
                        r_db_cnt  <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_db_cnt <= '0;
                    r_level  <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button debouncer; one independent key_debounce_ch per key.
// Long-press detection is enabled by defining KEY_LONG_PRESS_EN.
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS          = DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
                .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
            ) u_ch (
                .i_clk    (sys_clk),
                .i_rst_n  (sys_rst_n),
                .i_key_n  (key_n[g]),
                .o_level  (key_level[g]),
                .o_press  (key_press[g]),
                .o_release(key_release[g]),
                .o_long   (key_long[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed bounce/reset scenarios plus random traffic,
// checked every cycle against a run-length reference model.
module tb_key_debounce;

    localparam int NK   = 2;
    localparam int DB   = 4;
    localparam int LONG = 10;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [NK-1:0] key_n     = '1;
    logic [NK-1:0] key_level, key_press, key_release, key_long;

    key_debounce #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LONG)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(key_n),
        .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .key_long(key_long)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: an edge is accepted once the 2-cycle-delayed pin has disagreed with
    // the current level for DB+1 consecutive samples; long fires on the LONG-th
    // steady-pressed sample after acceptance, once per press.
    logic [NK-1:0] e_level = '0, e_press = '0, e_release = '0, e_long = '0;
    bit dl1 [NK];
    bit dl2 [NK];
    bit m_lvl [NK];
    bit m_fired [NK];
    int m_run [NK];
    int m_held [NK];

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            dl1[k] = 1'b1; dl2[k] = 1'b1; m_lvl[k] = 1'b0; m_fired[k] = 1'b0;
            m_run[k] = 0;  m_held[k] = 0;
        end
        e_level = '0; e_press = '0; e_release = '0; e_long = '0;
    endtask

    initial begin
        bit pr;
        int prev;
        model_reset();
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) begin
                model_reset();
            end else begin
                for (int k = 0; k < NK; k++) begin
                    pr      = !dl2[k];
                    dl2[k]  = dl1[k];
                    dl1[k]  = key_n[k];
                    e_press[k] = 1'b0; e_release[k] = 1'b0; e_long[k] = 1'b0;
                    prev = m_run[k];
                    if (pr != m_lvl[k]) m_run[k]++;
                    else                m_run[k] = 0;
                    if (m_run[k] == DB + 1) begin
                        m_lvl[k] = pr;
                        m_run[k] = 0;
                        if (pr) begin
                            e_press[k] = 1'b1; m_held[k] = 0; m_fired[k] = 1'b0;
                        end else begin
                            e_release[k] = 1'b1;
                        end
                    end else if (m_lvl[k] && prev == 0 && pr) begin
                        m_held[k]++;
                        if (m_held[k] == LONG && !m_fired[k]) begin
                            m_fired[k] = 1'b1;
                            if (LONG_EN) e_long[k] = 1'b1;
                        end
                    end
                    e_level[k] = m_lvl[k];
                end
            end
        end
    end

    // Per-cycle comparison and pulse tallies, sampled on the falling edge.
    int c_press [NK];
    int c_rel [NK];
    int c_long [NK];
    initial begin
        for (int k = 0; k < NK; k++) begin c_press[k] = 0; c_rel[k] = 0; c_long[k] = 0; end
        forever begin
            @(negedge sys_clk);
            chk("level",   32'(key_level),   32'(e_level));
            chk("press",   32'(key_press),   32'(e_press));
            chk("release", 32'(key_release), 32'(e_release));
            chk("long",    32'(key_long),    32'(e_long));
            chk("press_and_release", 32'(key_press & key_release), 32'd0);
            for (int k = 0; k < NK; k++) begin
                c_press[k] += int'(key_press[k]);
                c_rel[k]   += int'(key_release[k]);
                c_long[k]  += int'(key_long[k]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        int b0, b1, bl, hl;
        logic [NK-1:0] tgt;

        tick(2);
        chk("rst_level", 32'(key_level), 32'd0);
        chk("rst_press", 32'(key_press), 32'd0);
        #2 sys_rst_n = 1'b1;
        tick(3);

        // Clean press on key 0: pulse at edge 6 only.
        @(negedge sys_clk); key_n[0] = 1'b0;
        tick(6);
        chk("clean_e5_press", 32'(key_press[0]), 32'd0);
        tick(1);
        chk("clean_e6_press", 32'(key_press[0]), 32'd1);
        chk("clean_e6_level", 32'(key_level[0]), 32'd1);
        tick(1);
        chk("clean_e7_press", 32'(key_press[0]), 32'd0);
        chk("clean_e7_level", 32'(key_level[0]), 32'd1);

        // Long hold.
        b0 = c_long[0];
        tick(20);
        chk("long_count", 32'(c_long[0] - b0), LONG_EN ? 32'd1 : 32'd0);
        b0 = c_rel[0];
        key_n[0] = 1'b1;
        tick(10);
        chk("clean_release_count", 32'(c_rel[0] - b0), 32'd1);

        // Bouncy press: low 2, high 1, then low steady.
        b0 = c_press[0];
        @(negedge sys_clk); key_n[0] = 1'b0;
        tick(2); key_n[0] = 1'b1;
        tick(1); key_n[0] = 1'b0;
        tick(6);
        chk("bounce_e5_press", 32'(key_press[0]), 32'd0);
        tick(1);
        chk("bounce_e6_press", 32'(key_press[0]), 32'd1);
        tick(10);
        chk("bounce_press_count", 32'(c_press[0] - b0), 32'd1);

        // Bouncy release: high 2, low 1, then high steady.
        b0 = c_rel[0];
        @(negedge sys_clk); key_n[0] = 1'b1;
        tick(2); key_n[0] = 1'b0;
        tick(1); key_n[0] = 1'b1;
        tick(6);
        chk("glitch_e5_level", 32'(key_level[0]), 32'd1);
        tick(1);
        chk("glitch_e6_release", 32'(key_release[0]), 32'd1);
        chk("glitch_e6_level", 32'(key_level[0]), 32'd0);
        tick(10);
        chk("glitch_release_count", 32'(c_rel[0] - b0), 32'd1);

        // Both keys on one edge, independent releases.
        @(negedge sys_clk); key_n = 2'b00;
        tick(6);
        chk("both_e5_press", 32'(key_press), 32'd0);
        tick(1);
        chk("both_e6_press", 32'(key_press), 32'd3);
        b0 = c_rel[0]; b1 = c_rel[1];
        tick(3); key_n[0] = 1'b1;
        tick(12);
        chk("indep_rel0", 32'(c_rel[0] - b0), 32'd1);
        chk("indep_rel1_held", 32'(c_rel[1] - b1), 32'd0);
        chk("indep_level", 32'(key_level), 32'd2);
        key_n[1] = 1'b1;
        tick(12);
        chk("indep_rel1", 32'(c_rel[1] - b1), 32'd1);

        // Key 1 held across reset: no release, fresh press afterwards.
        key_n[1] = 1'b0;
        tick(10);
        b1 = c_rel[1];
        #2 sys_rst_n = 1'b0;
        tick(1);
        chk("mid_rst_outputs", 32'({key_level, key_press, key_release, key_long}), 32'd0);
        tick(3);
        chk("mid_rst_level", 32'(key_level), 32'd0);
        #2 sys_rst_n = 1'b1;
        tick(6);
        chk("rst_hold_e5_press", 32'(key_press[1]), 32'd0);
        tick(1);
        chk("rst_hold_e6_press", 32'(key_press[1]), 32'd1);
        chk("rst_no_release", 32'(c_rel[1] - b1), 32'd0);
        key_n[1] = 1'b1;
        tick(12);

        // Random bounce/steady segments with occasional reset pulses.
        for (int s = 0; s < 120; s++) begin
            tgt = NK'($urandom);
            bl  = int'($urandom_range(0, 5));
            hl  = int'($urandom_range(1, 24));
            for (int c = 0; c < bl + hl; c++) begin
                @(negedge sys_clk);
                key_n = (c < bl) ? NK'($urandom) : tgt;
            end
            if ($urandom_range(0, 19) == 0) begin
                #2 sys_rst_n = 1'b0;
                tick(2);
                #2 sys_rst_n = 1'b1;
            end
        end
        key_n = '1;
        tick(12);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
